sram_port: RTL and testbench
============================

Name: sram_port

Overview:
- Parametrised successor to the SoC word RAM.
- Single-port, byte-lane-writable data memory with a valid/ready request/response handshake and configurable read latency.
- Adds address-window decoding with an out-of-range error response.
- Sits between the core's load/store unit (or a bus arbiter) and on-chip storage; one transaction outstanding at a time.

Parameters:
- WORDS, 128, memory depth in 32-bit words; power of two, 16..65536.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to 4*WORDS.
- LATENCY, 1, cycles from request acceptance to rsp_valid; 1..4.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_we  in  4  byte-lane write enables; 0 = read; bit i covers wdata[8i+7:8i]
- req_addr  in  32  byte address; bits [1:0] ignored
- req_wdata  in  32  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_rdata  out  32  read data; 0 for writes and errors
- rsp_err  out  1  address outside window

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, counter 0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0. Memory contents are not reset.
- Reset asserted mid-transaction aborts it:
  - no response is produced;
  - a write already committed at acceptance stays committed.
- FSM IDLE:
  - req_ready=1.
  - On an edge with req_valid=1, the request is accepted. Compute idx = (req_addr-BASE_ADDR)>>2; in_range = BASE_ADDR <= req_addr < BASE_ADDR+4*WORDS (32-bit unsigned compare, no wrap).
  - Write (req_we≠0), in range: on the accept edge, lane i with req_we[i]=1 gets mem[idx][8i+7:8i] <= req_wdata[8i+7:8i]; other lanes are unchanged. Response data = 0.
  - Read, in range: response data = mem[idx] as stored before the accept edge.
  - Out of range: memory untouched; response data = 0; err = 1.
  - Next state: RESP if LATENCY=1, else WAIT with counter = LATENCY-1.
- FSM WAIT:
  - req_ready=0, rsp_valid=0.
  - Counter decrements each edge; at 1, next state is RESP.
- FSM RESP:
  - rsp_valid=1 with the captured rsp_rdata/rsp_err; req_ready=0.
  - rsp_rdata and rsp_err hold stable while rsp_ready=0.
  - On an edge with rsp_ready=1: to IDLE, rsp_valid=0, rsp_rdata and rsp_err cleared to 0.
- Timing:
  - rsp_valid is high exactly LATENCY cycles after the accept edge.
  - No accept in the same cycle as the response handshake, so peak throughput is one transaction per LATENCY+1 cycles.
- rsp_rdata is registered; no combinational path from req_* to rsp_*. req_ready depends only on state.
- Read-after-write: a read accepted after a write's response returns the merged data.
- req_we=4'hF is a full-word write; any lane mix is legal, including non-contiguous lanes.
- req_addr[1:0]≠0 is not an error; the low bits are dropped.
- Inputs other than req_valid are don't-care when req_valid=0.

Decomposition:
- Shared package sram_pkg holds:
  - typedef state_t {IDLE, WAIT, RESP};
  - localparams WORD_W=32 and LANES=4;
  - function lane_mask(we) expanding 4 enables to a 32-bit bit mask.
- One sub-module, sram_array: storage only, with inputs clk, we[3:0], idx, wdata and output rdata registered on the read strobe, so it maps to FPGA block RAM with byte enables.
- FSM, range decode and response register live in sram_port.

Test Plan:
- Reset then idle: after rst_n low→high, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Full write/read, LATENCY=1: write addr 0x10, we=F, data 0xDEADBEEF; response rsp_rdata=0, err=0 one cycle after accept. Then read 0x10 returns 0xDEADBEEF, rsp_valid one cycle after accept.
- Byte lanes: mem[4]=0x11223344 (addr 0x10). Write we=4'b0101, data 0xAABBCCDD, then read 0x10 → 0x11BB33DD. Read addr 0x13 also returns word 4.
- Out of range, WORDS=128, BASE=0: write addr 0x200 → err=1, rdata=0. Read 0x1FC → last word, err=0. No memory word changed.
- Latency and backpressure, LATENCY=3: rsp_valid rises exactly 3 cycles after accept. Hold rsp_ready=0 for 5 cycles → rsp_valid and data stable, req_ready=0. Release → IDLE next cycle.
- Reset mid-op, LATENCY=4: assert rst_n=0 in WAIT → rsp_valid=0 immediately, req_ready=1 after release. An aborted in-range write is still visible on a later read.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and helpers for the byte-lane SRAM port.
// Imported by the storage array, the port FSM and the bench.
package sram_pkg;

    localparam int WORD_W = 32;
    localparam int LANES  = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // Expand per-byte write enables to a per-bit mask.
    function automatic logic [WORD_W-1:0] lane_mask(
        input logic [LANES-1:0] we
    );
        logic [WORD_W-1:0] m;
        m = '0;
        for (int i = 0; i < LANES; i++) begin
            m[8*i +: 8] = {8{we[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/sram_array.sv
// Word storage with byte-lane writes and a registered read port.
// Shaped to map onto block RAM with byte enables.
module sram_array
    import sram_pkg::*;
#(
    parameter  int WORDS = 128,
    localparam int IW    = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              re,
    input  logic [LANES-1:0]  we,
    input  logic [IW-1:0]     idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_q [WORDS];
    logic [WORD_W-1:0] rdata_q;

    // Lane writes and read-before-write capture on the strobe edge.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (we[i]) begin
                mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (re) begin
            rdata_q <= mem_q[idx];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sram_port.sv
// Valid/ready front end: window decode, latency FSM and response.
// One transaction in flight; response data comes from registers only.
module sram_port
    import sram_pkg::*;
#(
    parameter int          WORDS     = 128,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          LATENCY   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [LANES-1:0]  req_we,
    input  logic [31:0]       req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int          IW   = $clog2(WORDS);
    localparam logic [31:0] SPAN = 32'(4 * WORDS);

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              rd_q;
    logic              err_q;
    logic [31:0]       off;
    logic              in_range;
    logic              accept;
    logic              arr_re;
    logic [LANES-1:0]  arr_we;
    logic [WORD_W-1:0] arr_rdata;

    // Window decode: below BASE is rejected before the offset is used.
    assign off      = req_addr - BASE_ADDR;
    assign in_range = (req_addr >= BASE_ADDR) && (off < SPAN);
    assign accept   = (state_q == IDLE) && req_valid;
    assign arr_we   = (accept && in_range) ? req_we : '0;
    assign arr_re   = accept && in_range && (req_we == '0);

    sram_array #(
        .WORDS (WORDS)
    ) u_array (
        .clk   (clk),
        .re    (arr_re),
        .we    (arr_we),
        .idx   (off[IW+1:2]),
        .wdata (req_wdata),
        .rdata (arr_rdata)
    );

    // State, latency counter and captured response kind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            rd_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                rd_q  <= arr_re;
                err_q <= !in_range;
            end
        end
    end

    // Next state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 2'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 2'd1) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Array read register holds until the next accept, so gating suffices.
    assign rsp_rdata = (rsp_valid && rd_q) ? arr_rdata : '0;
    assign rsp_err   = rsp_valid && err_q;

endmodule

// File: tb/tb_sram_port.sv
// Scoreboard bench: three ports with latency 1, 3 and 4.
// Stimulus pushes expected responses; a monitor pops on handshake.
module tb_sram_port;
    import sram_pkg::*;

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid [3];
    logic        req_ready [3];
    logic        rsp_valid [3];
    logic        rsp_err   [3];
    logic [31:0] rsp_rdata [3];
    logic [3:0]  req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_ready;

    exp_t sb [$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    function automatic int lat(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
    endfunction

    for (genvar k = 0; k < 3; k++) begin : g_dut
        sram_port #(
            .WORDS     (128),
            .BASE_ADDR (32'h0),
            .LATENCY   (lat(k))
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .req_valid (req_valid[k]),
            .req_ready (req_ready[k]),
            .req_we    (req_we),
            .req_addr  (req_addr),
            .req_wdata (req_wdata),
            .rsp_valid (rsp_valid[k]),
            .rsp_ready (rsp_ready),
            .rsp_rdata (rsp_rdata[k]),
            .rsp_err   (rsp_err[k])
        );
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // Monitor: pop and compare on every response handshake.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rsp_valid[k] === 1'b1 && rsp_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rsp_rdata", rsp_rdata[k], e.rd);
                    check("rsp_err", 32'(rsp_err[k]), 32'(e.err));
                end
            end
        end
    end

    task automatic txn(input int k, input logic [3:0] we,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input int hold);
        int cyc;
        exp_t e;
        @(negedge clk);
        check("req_ready_idle", 32'(req_ready[k]), 32'd1);
        req_valid[k] = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_wdata    = wd;
        e.rd  = exp_rd;
        e.err = exp_err;
        sb.push_back(e);
        @(posedge clk);
        #1;
        req_valid[k] = 1'b0;
        req_we       = 4'hx;
        req_addr     = 32'hx;
        rsp_ready    = (hold == 0);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!rsp_valid[k] && cyc < 12);
        check("latency", 32'(cyc), 32'(lat(k)));
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                check("hold_valid", 32'(rsp_valid[k]), 32'd1);
                check("hold_ready", 32'(req_ready[k]), 32'd0);
                check("hold_rdata", rsp_rdata[k], exp_rd);
                check("hold_err", 32'(rsp_err[k]), 32'(exp_err));
                if (i < hold - 1) @(negedge clk);
            end
            @(posedge clk);
            #1;
            rsp_ready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        check("idle_valid", 32'(rsp_valid[k]), 32'd0);
        check("idle_ready", 32'(req_ready[k]), 32'd1);
        check("idle_rdata", rsp_rdata[k], 32'd0);
        check("idle_err", 32'(rsp_err[k]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        req_we    = 4'h0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        for (int k = 0; k < 3; k++) req_valid[k] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("rst_req_ready", 32'(req_ready[k]), 32'd1);
            check("rst_rsp_valid", 32'(rsp_valid[k]), 32'd0);
            check("rst_rsp_rdata", rsp_rdata[k], 32'd0);
            check("rst_rsp_err", 32'(rsp_err[k]), 32'd0);
        end

        // Latency 1: full word, byte lanes, window edges.
        txn(0, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 0);
        txn(0, 4'h0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0);
        txn(0, 4'hF, 32'h10, 32'h11223344, 32'h0, 1'b0, 0);
        txn(0, 4'h5, 32'h10, 32'hAABBCCDD, 32'h0, 1'b0, 0);
        txn(0, 4'h0, 32'h10, 32'h0, 32'h11BB33DD, 1'b0, 0);
        txn(0, 4'h0, 32'h13, 32'h0, 32'h11BB33DD, 1'b0, 0);
        txn(0, 4'hF, 32'h0, 32'h0BADF00D, 32'h0, 1'b0, 0);
        txn(0, 4'hF, 32'h1FC, 32'hCAFEF00D, 32'h0, 1'b0, 0);
        txn(0, 4'hF, 32'h200, 32'h12345678, 32'h0, 1'b1, 0);
        txn(0, 4'h0, 32'h1FC, 32'h0, 32'hCAFEF00D, 1'b0, 0);
        txn(0, 4'h0, 32'h0, 32'h0, 32'h0BADF00D, 1'b0, 0);
        txn(0, 4'h0, 32'h200, 32'h0, 32'h0, 1'b1, 0);
        txn(0, 4'h0, 32'hFFFFFFFC, 32'h0, 32'h0, 1'b1, 0);
        txn(0, 4'h8, 32'h1FC, 32'h77000000, 32'h0, 1'b0, 0);
        txn(0, 4'h0, 32'h1FC, 32'h0, 32'h77FEF00D, 1'b0, 0);
        txn(0, 4'h0, 32'h10, 32'h0, 32'h11BB33DD, 1'b0, 0);

        // Latency 3 with five cycles of backpressure.
        txn(1, 4'hF, 32'h40, 32'h5A5A5A5A, 32'h0, 1'b0, 0);
        txn(1, 4'h0, 32'h40, 32'h0, 32'h5A5A5A5A, 1'b0, 5);
        txn(1, 4'h0, 32'h300, 32'h0, 32'h0, 1'b1, 5);

        // Latency 4: reset lands in WAIT; the write stays committed.
        @(negedge clk);
        req_valid[2] = 1'b1;
        req_we       = 4'hF;
        req_addr     = 32'h80;
        req_wdata    = 32'h13579BDF;
        @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        @(negedge clk);
        check("wait_ready", 32'(req_ready[2]), 32'd0);
        check("wait_valid", 32'(rsp_valid[2]), 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort_valid", 32'(rsp_valid[2]), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_ready", 32'(req_ready[2]), 32'd1);
        check("abort_valid2", 32'(rsp_valid[2]), 32'd0);
        txn(2, 4'h0, 32'h80, 32'h0, 32'h13579BDF, 1'b0, 0);

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
